// File: rtl/dcache_req_arbiter_pkg.sv
// Shared request/response types for the D$ request arbiter.
// arb_idx_t is sized for the largest supported requester count.
package dcache_req_arbiter_pkg;

   localparam int unsigned DCACHE_INDEX_WIDTH = 12;
   localparam int unsigned DCACHE_TAG_WIDTH   = 20;
   localparam int unsigned XLEN               = 64;
   localparam int unsigned DCACHE_ARB_MAX_PORTS = 8;

   typedef struct packed {
      logic [DCACHE_INDEX_WIDTH-1:0] address_index;
      logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
      logic [XLEN-1:0]               data_wdata;
      logic                          data_req;
      logic                          data_we;
      logic [XLEN/8-1:0]             data_be;
      logic [1:0]                    data_size;
      logic                          kill_req;
      logic                          tag_valid;
   } dcache_req_i_t;

   typedef struct packed {
      logic            data_gnt;
      logic            data_rvalid;
      logic [XLEN-1:0] data_rdata;
   } dcache_req_o_t;

   function automatic int unsigned dcache_arb_idx_w(
      input int unsigned n
   );
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DCACHE_ARB_IDX_W =
      dcache_arb_idx_w(DCACHE_ARB_MAX_PORTS);

   typedef logic [DCACHE_ARB_IDX_W-1:0] arb_idx_t;

endpackage

// File: rtl/dcache_arb_id_fifo.sv
// In-order FIFO of requester indices for outstanding D$ reads.
// DEPTH must be a power of two so the pointers wrap naturally.
module dcache_arb_id_fifo
   import dcache_req_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  arb_idx_t         data_i,
   input  logic             pop_i,
   output arb_idx_t         data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   arb_idx_t         mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is only legal alongside a pop.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Shares one D$ request port among NR_PORTS requesters (round-robin).
// Define DCACHE_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module dcache_req_arbiter
   import dcache_req_arbiter_pkg::*;
#(
   parameter int NR_PORTS      = 3,
   parameter int ID_FIFO_DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   input  dcache_req_i_t req_ports_i [NR_PORTS],
   output dcache_req_o_t req_ports_o [NR_PORTS],
   output dcache_req_i_t dcache_req_o,
   input  dcache_req_o_t dcache_req_i,
   output logic          idle_o
);

   localparam int unsigned CNT_W =
      ((ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1) + 1;

   logic [DCACHE_ARB_MAX_PORTS-1:0] elig;
   logic                            gnt_vld;
   arb_idx_t                        win;
   logic                            fire;
   logic                            push;
   logic                            pop;
   logic                            fifo_full;
   logic                            fifo_empty;
   arb_idx_t                        head;
   logic [CNT_W-1:0]                fifo_cnt;
   logic                            tag_phase_q, tag_phase_d;
   arb_idx_t                        tag_idx_q, tag_idx_d;

   // Full FIFO blocks reads only; flush blocks everything.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NR_PORTS; i++) begin
         elig[i] = req_ports_i[i].data_req
                 & (req_ports_i[i].data_we | ~fifo_full)
                 & ~flush_i;
      end
   end

`ifdef DCACHE_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt_vld = 1'b0;
      win     = '0;
      for (int i = NR_PORTS - 1; i >= 0; i--) begin
         if (elig[i]) begin
            gnt_vld = 1'b1;
            win     = arb_idx_t'(i);
         end
      end
   end
`else
   arb_idx_t rr_q, rr_d;
   arb_idx_t cand;

   // Scan downwards so the eligible port closest to rr_q wins.
   always_comb begin
      gnt_vld = 1'b0;
      win     = '0;
      cand    = '0;
      for (int j = NR_PORTS - 1; j >= 0; j--) begin
         if (int'(rr_q) + j >= NR_PORTS) begin
            cand = arb_idx_t'(int'(rr_q) + j - NR_PORTS);
         end else begin
            cand = arb_idx_t'(int'(rr_q) + j);
         end
         if (elig[cand]) begin
            gnt_vld = 1'b1;
            win     = cand;
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (fire) begin
         if (win == arb_idx_t'(NR_PORTS - 1)) rr_d = '0;
         else rr_d = win + arb_idx_t'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_q <= '0;
      else         rr_q <= rr_d;
   end
`endif

   assign fire = gnt_vld & dcache_req_i.data_gnt;
   assign push = fire & ~req_ports_i[win].data_we;
   assign pop  = dcache_req_i.data_rvalid & ~fifo_empty;

   always_comb begin
      tag_phase_d = push & ~flush_i;
      tag_idx_d   = push ? win : tag_idx_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tag_phase_q <= 1'b0;
         tag_idx_q   <= '0;
      end else begin
         tag_phase_q <= tag_phase_d;
         tag_idx_q   <= tag_idx_d;
      end
   end

   dcache_arb_id_fifo #(
      .DEPTH (ID_FIFO_DEPTH)
   ) i_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (win),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   // The pending tag phase owns address_tag over a new address phase.
   always_comb begin
      dcache_req_o = '0;
      if (gnt_vld) begin
         dcache_req_o.address_index = req_ports_i[win].address_index;
         dcache_req_o.data_wdata    = req_ports_i[win].data_wdata;
         dcache_req_o.data_we       = req_ports_i[win].data_we;
         dcache_req_o.data_be       = req_ports_i[win].data_be;
         dcache_req_o.data_size     = req_ports_i[win].data_size;
         dcache_req_o.data_req      = 1'b1;
         dcache_req_o.address_tag   = req_ports_i[win].address_tag;
      end
      if (tag_phase_q) begin
         dcache_req_o.address_tag = req_ports_i[tag_idx_q].address_tag;
         dcache_req_o.tag_valid   = req_ports_i[tag_idx_q].tag_valid
                                  & ~flush_i;
         dcache_req_o.kill_req    = req_ports_i[tag_idx_q].kill_req
                                  | flush_i;
      end
   end

   always_comb begin
      for (int i = 0; i < NR_PORTS; i++) begin
         req_ports_o[i] = '0;
         req_ports_o[i].data_gnt = fire & (win == arb_idx_t'(i));
         if (pop && head == arb_idx_t'(i)) begin
            req_ports_o[i].data_rvalid = 1'b1;
            req_ports_o[i].data_rdata  = dcache_req_i.data_rdata;
         end
      end
   end

   assign idle_o = ~tag_phase_q & (fifo_cnt == '0);

`ifndef SYNTHESIS
   rvalid_has_id: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      dcache_req_i.data_rvalid |-> !fifo_empty
   ) else $error("rvalid with no outstanding read ID");
`endif

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Directed bench for dcache_req_arbiter; expectations follow
// DCACHE_ARB_FIXED_PRIO_EN where arbitration order differs.
module tb_dcache_req_arbiter;
   import dcache_req_arbiter_pkg::*;

   localparam int NP    = 3;
   localparam int DEPTH = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          flush_i;
   dcache_req_i_t req_in  [NP];
   dcache_req_o_t req_out [NP];
   dcache_req_i_t dc_req;
   dcache_req_o_t dc_rsp;
   logic          idle;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   dcache_req_arbiter #(
      .NR_PORTS      (NP),
      .ID_FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .req_ports_i  (req_in),
      .req_ports_o  (req_out),
      .dcache_req_o (dc_req),
      .dcache_req_i (dc_rsp),
      .idle_o       (idle)
   );

   function automatic logic [19:0] tag_of(input int p);
      return 20'(32'h100 + p);
   endfunction

   function automatic logic [11:0] idx_of(input int p);
      return 12'(16 * p + 1);
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_rq(input int p, input logic we);
      req_in[p].data_req      = 1'b1;
      req_in[p].data_we       = we;
      req_in[p].address_index = idx_of(p);
      req_in[p].address_tag   = tag_of(p);
      req_in[p].data_wdata    = 64'(32'h1000 + p);
      req_in[p].data_be       = 8'hff;
      req_in[p].data_size     = 2'd3;
      req_in[p].tag_valid     = 1'b1;
      req_in[p].kill_req      = 1'b0;
   endtask

   task automatic drop(input int p);
      req_in[p].data_req = 1'b0;
   endtask

   task automatic rsp(input logic v, input logic [63:0] d);
      dc_rsp.data_rvalid = v;
      dc_rsp.data_rdata  = d;
   endtask

   task automatic test_reset();
      checks++;
      if (idle !== 1'b1) begin
         errors++;
         $display("FAIL reset_idle: got %b expected 1", idle);
      end
      checks++;
      if (dc_req !== '0) begin
         errors++;
         $display("FAIL reset_dcreq: got %h expected 0", dc_req);
      end
      for (int p = 0; p < NP; p++) begin
         checks++;
         if (req_out[p] !== '0) begin
            errors++;
            $display("FAIL reset_port%0d: got %h expected 0",
                     p, req_out[p]);
         end
      end
   endtask

   task automatic test_round_robin();
      int cnt [NP];
      int ew  [4];
      int nv;
      cnt = '{2, 1, 1};
`ifdef DCACHE_ARB_FIXED_PRIO_EN
      ew = '{0, 0, 1, 2};
`else
      ew = '{0, 1, 2, 0};
`endif
      dc_rsp.data_gnt = 1'b1;
      for (int c = 0; c < 4; c++) begin
         for (int p = 0; p < NP; p++) begin
            if (cnt[p] > 0) set_rq(p, 1'b0);
            else drop(p);
         end
         #1;
         for (int p = 0; p < NP; p++) begin
            checks++;
            if (req_out[p].data_gnt !== (p == ew[c])) begin
               errors++;
               $display("FAIL rr_gnt c%0d p%0d: got %b expected %b",
                        c, p, req_out[p].data_gnt, (p == ew[c]));
            end
         end
         checks++;
         if (dc_req.address_index !== idx_of(ew[c])) begin
            errors++;
            $display("FAIL rr_index c%0d: got %h expected %h",
                     c, dc_req.address_index, idx_of(ew[c]));
         end
         checks++;
         if (c == 0) begin
            if (dc_req.tag_valid !== 1'b0) begin
               errors++;
               $display("FAIL rr_tagv c0: got %b expected 0",
                        dc_req.tag_valid);
            end
         end else if (dc_req.tag_valid !== 1'b1 ||
                      dc_req.address_tag !== tag_of(ew[c-1])) begin
            errors++;
            $display("FAIL rr_tag c%0d: got %b/%h expected 1/%h",
                     c, dc_req.tag_valid, dc_req.address_tag,
                     tag_of(ew[c-1]));
         end
         cnt[ew[c]]--;
         tick();
      end
      for (int p = 0; p < NP; p++) drop(p);
      #1;
      checks++;
      if (dc_req.tag_valid !== 1'b1 || dc_req.data_req !== 1'b0 ||
          dc_req.address_tag !== tag_of(ew[3])) begin
         errors++;
         $display("FAIL rr_last_tag: got %b/%b/%h expected 1/0/%h",
                  dc_req.tag_valid, dc_req.data_req,
                  dc_req.address_tag, tag_of(ew[3]));
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         rsp(1'b1, 64'(32'hA + k));
         #1;
         nv = 0;
         for (int p = 0; p < NP; p++) nv += int'(req_out[p].data_rvalid);
         checks++;
         if (req_out[ew[k]].data_rvalid !== 1'b1 || nv != 1 ||
             req_out[ew[k]].data_rdata !== 64'(32'hA + k)) begin
            errors++;
            $display("FAIL rr_resp k%0d: got %b/%0d/%h expected 1/1/%h",
                     k, req_out[ew[k]].data_rvalid, nv,
                     req_out[ew[k]].data_rdata, 32'hA + k);
         end
         tick();
      end
      rsp(1'b0, '0);
      #1;
      checks++;
      if (idle !== 1'b1) begin
         errors++;
         $display("FAIL rr_idle: got %b expected 1", idle);
      end
   endtask

   task automatic test_fifo_full();
      int ep [4];
      ep = '{0, 0, 0, 1};
      for (int c = 0; c < 4; c++) begin
         set_rq(0, 1'b0);
         #1;
         checks++;
         if (req_out[0].data_gnt !== 1'b1) begin
            errors++;
            $display("FAIL fill_gnt c%0d: got %b expected 1",
                     c, req_out[0].data_gnt);
         end
         tick();
      end
      set_rq(0, 1'b1);
      set_rq(1, 1'b0);
      #1;
      checks++;
      if (req_out[0].data_gnt !== 1'b1 || req_out[1].data_gnt !== 1'b0 ||
          dc_req.data_we !== 1'b1 || dc_req.data_wdata !== 64'h1000) begin
         errors++;
         $display("FAIL full_write: got %b/%b/%b/%h expected 1/0/1/1000",
                  req_out[0].data_gnt, req_out[1].data_gnt,
                  dc_req.data_we, dc_req.data_wdata);
      end
      tick();
      drop(0);
      #1;
      checks++;
      if (req_out[1].data_gnt !== 1'b0 || dc_req.data_req !== 1'b0) begin
         errors++;
         $display("FAIL full_block: got %b/%b expected 0/0",
                  req_out[1].data_gnt, dc_req.data_req);
      end
      tick();
      rsp(1'b1, 64'h55);
      #1;
      checks++;
      if (req_out[1].data_gnt !== 1'b0 ||
          req_out[0].data_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL full_prepop: got gnt %b rvalid %b expected 0/1",
                  req_out[1].data_gnt, req_out[0].data_rvalid);
      end
      tick();
      rsp(1'b0, '0);
      #1;
      checks++;
      if (req_out[1].data_gnt !== 1'b1) begin
         errors++;
         $display("FAIL full_after_pop: got %b expected 1",
                  req_out[1].data_gnt);
      end
      tick();
      drop(1);
      for (int k = 0; k < 4; k++) begin
         rsp(1'b1, 64'(32'h60 + k));
         #1;
         checks++;
         if (req_out[ep[k]].data_rvalid !== 1'b1 ||
             req_out[ep[k]].data_rdata !== 64'(32'h60 + k)) begin
            errors++;
            $display("FAIL full_drain k%0d: got %b/%h expected 1/%h",
                     k, req_out[ep[k]].data_rvalid,
                     req_out[ep[k]].data_rdata, 32'h60 + k);
         end
         tick();
      end
      rsp(1'b0, '0);
      #1;
      checks++;
      if (idle !== 1'b1) begin
         errors++;
         $display("FAIL full_idle: got %b expected 1", idle);
      end
   endtask

   task automatic test_flush();
      set_rq(2, 1'b0);
      #1;
      checks++;
      if (req_out[2].data_gnt !== 1'b1) begin
         errors++;
         $display("FAIL flush_pre_gnt: got %b expected 1",
                  req_out[2].data_gnt);
      end
      tick();
      drop(2);
      set_rq(0, 1'b0);
      flush_i = 1'b1;
      #1;
      checks++;
      if (dc_req.kill_req !== 1'b1 || dc_req.tag_valid !== 1'b0 ||
          dc_req.data_req !== 1'b0 || req_out[0].data_gnt !== 1'b0) begin
         errors++;
         $display("FAIL flush_cycle: got %b/%b/%b/%b expected 1/0/0/0",
                  dc_req.kill_req, dc_req.tag_valid,
                  dc_req.data_req, req_out[0].data_gnt);
      end
      tick();
      flush_i = 1'b0;
      drop(0);
      #1;
      checks++;
      if (dc_req.kill_req !== 1'b0 || dc_req.tag_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_after: got %b/%b expected 0/0",
                  dc_req.kill_req, dc_req.tag_valid);
      end
      set_rq(1, 1'b0);
      #1;
      checks++;
      if (req_out[1].data_gnt !== 1'b1) begin
         errors++;
         $display("FAIL kill_gnt: got %b expected 1",
                  req_out[1].data_gnt);
      end
      tick();
      drop(1);
      req_in[1].kill_req = 1'b1;
      #1;
      checks++;
      if (dc_req.kill_req !== 1'b1 || dc_req.tag_valid !== 1'b1) begin
         errors++;
         $display("FAIL kill_fwd: got %b/%b expected 1/1",
                  dc_req.kill_req, dc_req.tag_valid);
      end
      tick();
      req_in[1].kill_req = 1'b0;
      rsp(1'b1, 64'hE);
      #1;
      checks++;
      if (req_out[2].data_rvalid !== 1'b1 ||
          req_out[2].data_rdata !== 64'hE ||
          req_out[0].data_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL flush_resp: got %b/%h expected 1/e",
                  req_out[2].data_rvalid, req_out[2].data_rdata);
      end
      tick();
      rsp(1'b1, 64'hF);
      #1;
      checks++;
      if (req_out[1].data_rvalid !== 1'b1 ||
          req_out[1].data_rdata !== 64'hF) begin
         errors++;
         $display("FAIL kill_resp: got %b/%h expected 1/f",
                  req_out[1].data_rvalid, req_out[1].data_rdata);
      end
      tick();
      rsp(1'b0, '0);
      #1;
      checks++;
      if (idle !== 1'b1) begin
         errors++;
         $display("FAIL flush_idle: got %b expected 1", idle);
      end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         set_rq(0, 1'b0);
         tick();
      end
      drop(0);
      #1;
      checks++;
      if (idle !== 1'b0) begin
         errors++;
         $display("FAIL mid_busy: got %b expected 0", idle);
      end
      #1;
      rst_ni = 1'b0;
      #1;
      test_reset();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      set_rq(0, 1'b0);
      set_rq(2, 1'b0);
      #1;
      checks++;
      if (req_out[0].data_gnt !== 1'b1 ||
          req_out[2].data_gnt !== 1'b0) begin
         errors++;
         $display("FAIL mid_first: got %b/%b expected 1/0",
                  req_out[0].data_gnt, req_out[2].data_gnt);
      end
      tick();
      drop(0);
      #1;
      checks++;
      if (req_out[2].data_gnt !== 1'b1) begin
         errors++;
         $display("FAIL mid_second: got %b expected 1",
                  req_out[2].data_gnt);
      end
      tick();
      drop(2);
      rsp(1'b1, 64'h21);
      #1;
      checks++;
      if (req_out[0].data_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL mid_resp0: got %b expected 1",
                  req_out[0].data_rvalid);
      end
      tick();
      rsp(1'b1, 64'h22);
      #1;
      checks++;
      if (req_out[2].data_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL mid_resp2: got %b expected 1",
                  req_out[2].data_rvalid);
      end
      tick();
      rsp(1'b0, '0);
   endtask

   task automatic test_prio();
      int ew [4];
`ifdef DCACHE_ARB_FIXED_PRIO_EN
      ew = '{0, 0, 0, 0};
`else
      ew = '{0, 2, 0, 2};
`endif
      set_rq(0, 1'b1);
      set_rq(2, 1'b1);
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (req_out[0].data_gnt !== (ew[c] == 0) ||
             req_out[2].data_gnt !== (ew[c] == 2)) begin
            errors++;
            $display("FAIL prio_gnt c%0d: got %b/%b expected port %0d",
                     c, req_out[0].data_gnt, req_out[2].data_gnt, ew[c]);
         end
         tick();
      end
      drop(0);
      #1;
      checks++;
      if (req_out[2].data_gnt !== 1'b1) begin
         errors++;
         $display("FAIL prio_drop: got %b expected 1",
                  req_out[2].data_gnt);
      end
      tick();
      drop(2);
      #1;
      checks++;
      if (idle !== 1'b1) begin
         errors++;
         $display("FAIL prio_idle: got %b expected 1", idle);
      end
   endtask

   initial begin
      rst_ni  = 1'b0;
      flush_i = 1'b0;
      dc_rsp  = '0;
      for (int p = 0; p < NP; p++) req_in[p] = '0;
      #2;
      test_reset();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      test_round_robin();
      test_fifo_full();
      test_flush();
      test_reset_mid();
      test_prio();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_req_arbiter.md
Name: dcache_req_arbiter

Overview:
Shares one D$ request port between NR_PORTS requesters, for example store buffer, AMO/load path and PTW. It arbitrates the address phase and forwards the tag phase from the winner one cycle later. It routes each read response back to its originating port in order, using an in-order ID FIFO. It sits between the load/store unit requesters and the D$ port.

Parameters:
NR_PORTS, 3, number of requesters (2..8); port 0 is the lowest index.
ID_FIFO_DEPTH, 4, maximum outstanding reads awaiting data_rvalid (power of 2).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
flush_i  in  1  abort the pending tag phase; outstanding read IDs are retained
req_ports_i  in  NR_PORTS x dcache_req_i_t  requester-side requests (address, tag, we, be, size, data, kill_req, tag_valid)
req_ports_o  out  NR_PORTS x dcache_req_o_t  per-requester data_gnt / data_rvalid / data_rdata
dcache_req_o  out  dcache_req_i_t  muxed request to the D$
dcache_req_i  in  dcache_req_o_t  D$ response
idle_o  out  1  no tag phase pending and ID FIFO empty

Behaviour:
- Reset: rr pointer = 0, tag_phase_q = 0, tag_idx_q = 0, FIFO empty.
- Reset outputs: all req_ports_o fields 0; dcache_req_o all 0; idle_o = 1.
- Eligibility: port i is eligible if data_req = 1, unless it is a read (data_we = 0) and the FIFO is full. A full FIFO blocks reads only; writes remain eligible.
- Arbitration (combinational, same cycle):
  - Round-robin among eligible ports, starting at rr pointer.
  - Winner's address, we, be, size and wdata drive dcache_req_o with data_req = 1.
  - dcache_req_i.data_gnt goes only to the winner's req_ports_o[i].data_gnt.
  - Non-winners see data_gnt = 0 and must hold their request stable.
- On data_req & data_gnt:
  - rr pointer advances to winner+1, mod NR_PORTS.
  - Read (we = 0): push winner index into the FIFO; set tag_phase_q = 1 and tag_idx_q = winner for the next cycle.
  - Write: no push and no tag phase. Writes carry the full address in the address phase and get no rvalid.
- Tag phase (cycle after a read grant):
  - dcache_req_o.address_tag, tag_valid and kill_req come from req_ports_i[tag_idx_q].
  - In all other cycles, tag_valid = 0 and kill_req = 0.
  - A new address phase may be granted in the same cycle (pipelined; back-to-back reads allowed).
- Response: data_rvalid & data_rdata go to the port at the FIFO head; that cycle pops the FIFO. All other ports see data_rvalid = 0.
- Simultaneous push and pop: allowed, occupancy unchanged, including when the FIFO is full. The full check for eligibility uses the pre-pop count; no bypass.
- kill_req during the tag phase: forwarded to the D$. The D$ still returns a (dropped) rvalid, so the ID stays in the FIFO and is popped normally.
- flush_i:
  - Clears tag_phase_q; forces dcache_req_o.kill_req = 1 if a tag phase is active that cycle.
  - Masks new grants in the flush cycle.
  - FIFO is not cleared; in-flight responses drain normally.
- rvalid with FIFO empty: protocol error; response dropped. Covered by a simulation assertion.
- Wrap-around: FIFO pointers are log2(ID_FIFO_DEPTH) bits and wrap naturally; a separate count register is log2+1 bits.
- Reset mid-operation: all state cleared asynchronously; in-flight responses after reset are a D$ contract violation.
- idle_o = !tag_phase_q & (count == 0).

Optional Feature:
DCACHE_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest eligible index wins; rr pointer is not instantiated.
- Undefined (default): round-robin as above.
- Both modes apply the same full-FIFO masking and flush masking.

Decomposition:
- Shared package (ariane_pkg): dcache_req_i_t, dcache_req_o_t (existing).
- New in package: localparam DCACHE_ARB_IDX_W = $clog2(NR_PORTS) as a function, and a typedef arb_idx_t.
- Sub-module: dcache_arb_id_fifo, a simple synchronous FIFO of arb_idx_t.
  - Interface: push/pop/full/empty/count; async active-low reset; no flush input.
- Top: arbitration logic, tag-phase register, muxes.

Test Plan:
1. Ports 0, 1 and 2 all issue reads, D$ grants every cycle → grant order 0, 1, 2, 0 (round-robin). Tag forwarded one cycle after each grant. rvalid data 0xA, 0xB, 0xC returned to ports 0, 1, 2 in that order.
2. Four reads outstanding (ID_FIFO_DEPTH = 4), no rvalid, port 1 read plus port 0 write → port 1 is not granted; port 0 write is granted. After one rvalid pops, port 1 is granted next cycle.
3. FIFO full, rvalid and a new read grant in the same cycle → the pre-pop full check blocks the grant that cycle. Next cycle the grant occurs; count stays 4 with no overflow.
4. flush_i asserted in the cycle after a port 2 read grant → dcache_req_o.kill_req = 1, tag_valid = 0, no grant that cycle. Later rvalid still pops port 2's entry and routes to port 2.
5. rst_ni low with 3 outstanding reads → all req_ports_o 0, idle_o = 1. First request after reset arbitrates from port 0.
6. DCACHE_ARB_FIXED_PRIO_EN defined, ports 0 and 2 requesting continuously → port 0 always wins; port 2 is granted only when port 0 drops data_req.
